// File: rtl/tag_ram_cmp_rw_pkg.sv
// Shared types and elaboration helpers for the multi-way tag RAM.
package tag_ram_pkg;

    // Top-level sequencing: INIT runs the clear sweep, RUN serves requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ceiling log2, for deriving index and way-select widths at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Way-select width; a single-way build still carries a 1-bit selector.
    function automatic int way_width(input int ways);
        return (ways <= 1) ? 1 : clog2(ways);
    endfunction

endpackage

// File: rtl/tag_ram_cmp_rw_if.sv
// Request/response bundle between the cache controller and the tag RAM.
interface tag_ram_cmp_rw_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7,
    parameter int WAYS   = 2
);
    import tag_ram_pkg::*;

    localparam int WWIDTH = way_width(WAYS);

    logic                     ready;
    logic                     rd_en;
    logic [AWIDTH-1:0]        rd_addr;
    logic [DWIDTH-1:0]        rd_tag;
    logic                     wr_en;
    logic                     wr_inv;
    logic [AWIDTH-1:0]        wr_addr;
    logic [WWIDTH-1:0]        wr_way;
    logic [DWIDTH-1:0]        din;
    logic                     rd_valid;
    logic                     rd_hit;
    logic [WWIDTH-1:0]        rd_way;
    logic                     rd_multi;
    logic [WAYS*DWIDTH-1:0]   dout;
    logic [WAYS-1:0]          dout_vld;

    // Cache controller side.
    modport master (
        input  ready, rd_valid, rd_hit, rd_way, rd_multi, dout, dout_vld,
        output rd_en, rd_addr, rd_tag, wr_en, wr_inv, wr_addr, wr_way, din
    );

    // Tag RAM side.
    modport slave (
        output ready, rd_valid, rd_hit, rd_way, rd_multi, dout, dout_vld,
        input  rd_en, rd_addr, rd_tag, wr_en, wr_inv, wr_addr, wr_way, din
    );

endinterface

// File: rtl/tag_ram_cmp_rw_way.sv
// One way of the tag store: tag array, per-entry valid bits, registered read.
module tag_ram_way #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7
) (
    input  logic              clock,
    input  logic              clr_i,
    input  logic [AWIDTH-1:0] clr_addr_i,
    input  logic              we_i,
    input  logic              inv_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rtag_o,
    output logic              rvld_o
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DWIDTH-1:0] rtag_q;
    logic              rvld_q;

    // Array update: the clear sweep wins; an invalidate leaves the tag intact.
    always_ff @(posedge clock) begin
        if (clr_i) begin
            tag_q[clr_addr_i] <= '0;
            vld_q[clr_addr_i] <= 1'b0;
        end else if (we_i) begin
            vld_q[waddr_i] <= !inv_i;
            if (!inv_i) tag_q[waddr_i] <= din_i;
        end
    end

    // Registered read returns the contents as they stood before this edge.
    always_ff @(posedge clock) begin
        if (re_i) begin
            rtag_q <= tag_q[raddr_i];
            rvld_q <= vld_q[raddr_i];
        end
    end

    assign rtag_o = rtag_q;
    assign rvld_o = rvld_q;

endmodule

// File: rtl/tag_ram_cmp_rw.sv
// Multi-way tag RAM with in-pipeline compare, clear sweep after reset and
// optional write-first bypass on same-index read/write collisions.
module tag_ram_cmp_rw
    import tag_ram_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7,
    parameter int WAYS   = 2,
    parameter int BYPASS = 1
) (
    input logic             clock,
    input logic             reset,
    tag_ram_cmp_rw_if.slave bus
);
    localparam int                DEPTH    = 1 << AWIDTH;
    localparam int                WWIDTH   = way_width(WAYS);
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    logic run, sweep, rd_acc, wr_acc, collide;

    logic [DWIDTH-1:0] way_tag [WAYS];
    logic [WAYS-1:0]   way_vld;

    logic              rd_pend_q;
    logic [DWIDTH-1:0] rd_tag_q;
    logic [WAYS-1:0]   byp_way_q;
    logic              byp_inv_q;
    logic [DWIDTH-1:0] byp_din_q;

    logic [DWIDTH-1:0]      mtag [WAYS];
    logic [WAYS-1:0]        mvld;
    logic [WAYS-1:0]        hit;
    logic [3:0]             hit_cnt;
    logic                   rd_hit_d, rd_multi_d;
    logic [WWIDTH-1:0]      rd_way_d;
    logic [WAYS*DWIDTH-1:0] dout_d;

    logic                   rd_valid_q, rd_hit_q, rd_multi_q;
    logic [WWIDTH-1:0]      rd_way_q;
    logic [WAYS*DWIDTH-1:0] dout_q;
    logic [WAYS-1:0]        dout_vld_q;

    assign run     = (state_q == RUN);
    assign sweep   = (state_q == INIT);
    assign rd_acc  = run && !reset && bus.rd_en;
    assign wr_acc  = run && !reset && bus.wr_en;
    assign collide = (BYPASS != 0) && rd_acc && wr_acc && (bus.rd_addr == bus.wr_addr);

    // State and sweep counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep every index once, then hand over to normal operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // ---- stage 0: request accepted, ways perform their registered read ----
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_ram_way #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH)
        ) u_way (
            .clock      (clock),
            .clr_i      (sweep),
            .clr_addr_i (cnt_q),
            .we_i       (wr_acc && (bus.wr_way == WWIDTH'(w))),
            .inv_i      (bus.wr_inv),
            .waddr_i    (bus.wr_addr),
            .din_i      (bus.din),
            .re_i       (rd_acc),
            .raddr_i    (bus.rd_addr),
            .rtag_o     (way_tag[w]),
            .rvld_o     (way_vld[w])
        );
    end

    // Pending-read flag; cleared by reset so an aborted read never pulses.
    always_ff @(posedge clock) begin
        if (reset) rd_pend_q <= 1'b0;
        else       rd_pend_q <= rd_acc;
    end

    // Capture the compare tag and any same-index write to fold into the result.
    always_ff @(posedge clock) begin
        if (rd_acc) begin
            rd_tag_q  <= bus.rd_tag;
            byp_inv_q <= bus.wr_inv;
            byp_din_q <= bus.din;
            for (int w = 0; w < WAYS; w++) begin
                byp_way_q[w] <= collide && (bus.wr_way == WWIDTH'(w));
            end
        end
    end

    // ---- stage 1: merge bypass, compare, priority-encode, count hits ----
    always_comb begin
        hit        = '0;
        hit_cnt    = '0;
        mvld       = '0;
        rd_way_d   = '0;
        dout_d     = '0;
        for (int w = 0; w < WAYS; w++) begin
            mtag[w] = way_tag[w];
            mvld[w] = way_vld[w];
            if (byp_way_q[w]) begin
                mvld[w] = !byp_inv_q;
                if (!byp_inv_q) mtag[w] = byp_din_q;
            end
            hit[w] = mvld[w] && (mtag[w] == rd_tag_q);
            hit_cnt = hit_cnt + 4'(hit[w]);
            dout_d[w*DWIDTH +: DWIDTH] = mtag[w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w]) rd_way_d = WWIDTH'(w);
        end
        rd_hit_d   = (hit_cnt != 4'd0);
        rd_multi_d = (hit_cnt > 4'd1);
    end

    // Result registers: data holds between reads, rd_valid pulses per read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_way_q   <= '0;
            rd_multi_q <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= '0;
        end else begin
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_hit_q   <= rd_hit_d;
                rd_way_q   <= rd_way_d;
                rd_multi_q <= rd_multi_d;
                dout_q     <= dout_d;
                dout_vld_q <= mvld;
            end
        end
    end

    assign bus.ready    = run;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_hit   = rd_hit_q;
    assign bus.rd_way   = rd_way_q;
    assign bus.rd_multi = rd_multi_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;

endmodule

// File: tb/tb_tag_ram_cmp_rw.sv
// Bench for tag_ram_cmp_rw: a write-first and a read-first instance share one
// stimulus stream and are compared against an array model every cycle.
module tb_tag_ram_cmp_rw;
    localparam int AW    = 3;
    localparam int DW    = 7;
    localparam int NW    = 2;
    localparam int WW    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          rd_en, wr_en, wr_inv;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_tag, din;
    logic [WW-1:0] wr_way;

    tag_ram_cmp_rw_if #(.AWIDTH(AW), .DWIDTH(DW), .WAYS(NW)) if0 ();
    tag_ram_cmp_rw_if #(.AWIDTH(AW), .DWIDTH(DW), .WAYS(NW)) if1 ();

    assign if0.rd_en = rd_en;  assign if0.rd_addr = rd_addr;  assign if0.rd_tag = rd_tag;
    assign if0.wr_en = wr_en;  assign if0.wr_inv  = wr_inv;   assign if0.wr_addr = wr_addr;
    assign if0.wr_way = wr_way; assign if0.din = din;
    assign if1.rd_en = rd_en;  assign if1.rd_addr = rd_addr;  assign if1.rd_tag = rd_tag;
    assign if1.wr_en = wr_en;  assign if1.wr_inv  = wr_inv;   assign if1.wr_addr = wr_addr;
    assign if1.wr_way = wr_way; assign if1.din = din;

    tag_ram_cmp_rw #(.AWIDTH(AW), .DWIDTH(DW), .WAYS(NW), .BYPASS(1)) dut0 (
        .clock(clock), .reset(reset), .bus(if0));
    tag_ram_cmp_rw #(.AWIDTH(AW), .DWIDTH(DW), .WAYS(NW), .BYPASS(0)) dut1 (
        .clock(clock), .reset(reset), .bus(if1));

    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model: plain arrays, sweep modelled as a countdown.
    int            m_tag [NW][DEPTH];
    bit            m_vld [NW][DEPTH];
    bit            m_ready = 1'b0;
    int            m_sweep = DEPTH;
    bit            m_pend  = 1'b0;
    bit            e_val   = 1'b0;
    bit            e_hit [2], p_hit [2];
    int            e_way [2], p_way [2];
    bit            e_multi [2], p_multi [2];
    logic [NW*DW-1:0] e_dout [2], p_dout [2];
    logic [NW-1:0]    e_dvld [2], p_dvld [2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Result a read would return; byp selects write-first collision handling.
    task automatic model_read(input int d, input bit byp);
        int cnt;
        cnt = 0;
        p_way[d] = 0;
        p_dout[d] = '0;
        p_dvld[d] = '0;
        for (int w = 0; w < NW; w++) begin
            int t;
            bit v;
            t = m_tag[w][rd_addr];
            v = m_vld[w][rd_addr];
            if (byp && wr_en && (wr_addr == rd_addr) && (int'(wr_way) == w)) begin
                v = !wr_inv;
                if (!wr_inv) t = int'(din);
            end
            p_dout[d][w*DW +: DW] = DW'(t);
            p_dvld[d][w] = v;
            if (v && (t == int'(rd_tag))) begin
                if (cnt == 0) p_way[d] = w;
                cnt++;
            end
        end
        p_hit[d]   = (cnt > 0);
        p_multi[d] = (cnt > 1);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_ready = 1'b0;
            m_sweep = DEPTH;
            m_pend  = 1'b0;
            e_val   = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e_hit[d] = 1'b0; e_way[d] = 0; e_multi[d] = 1'b0;
                e_dout[d] = '0;  e_dvld[d] = '0;
            end
        end else begin
            e_val = m_pend;
            if (m_pend) begin
                for (int d = 0; d < 2; d++) begin
                    e_hit[d] = p_hit[d]; e_way[d] = p_way[d]; e_multi[d] = p_multi[d];
                    e_dout[d] = p_dout[d]; e_dvld[d] = p_dvld[d];
                end
            end
            m_pend = 1'b0;
            if (!m_ready) begin
                if (m_sweep > 0) begin
                    m_sweep--;
                    if (m_sweep == 0) begin
                        for (int w = 0; w < NW; w++)
                            for (int i = 0; i < DEPTH; i++) begin
                                m_tag[w][i] = 0;
                                m_vld[w][i] = 1'b0;
                            end
                        m_ready = 1'b1;
                    end
                end
            end else begin
                if (rd_en) begin
                    model_read(0, 1'b1);
                    model_read(1, 1'b0);
                    m_pend = 1'b1;
                end
                if (wr_en && (int'(wr_way) < NW)) begin
                    m_vld[wr_way][wr_addr] = !wr_inv;
                    if (!wr_inv) m_tag[wr_way][wr_addr] = int'(din);
                end
            end
        end
    endtask

    task automatic model_check();
        chk("m0.ready",    64'(if0.ready),    64'(m_ready));
        chk("m1.ready",    64'(if1.ready),    64'(m_ready));
        chk("m0.rd_valid", 64'(if0.rd_valid), 64'(e_val));
        chk("m1.rd_valid", 64'(if1.rd_valid), 64'(e_val));
        chk("m0.rd_hit",   64'(if0.rd_hit),   64'(e_hit[0]));
        chk("m1.rd_hit",   64'(if1.rd_hit),   64'(e_hit[1]));
        chk("m0.rd_way",   64'(if0.rd_way),   64'(e_way[0]));
        chk("m1.rd_way",   64'(if1.rd_way),   64'(e_way[1]));
        chk("m0.rd_multi", 64'(if0.rd_multi), 64'(e_multi[0]));
        chk("m1.rd_multi", 64'(if1.rd_multi), 64'(e_multi[1]));
        chk("m0.dout",     64'(if0.dout),     64'(e_dout[0]));
        chk("m1.dout",     64'(if1.dout),     64'(e_dout[1]));
        chk("m0.dout_vld", 64'(if0.dout_vld), 64'(e_dvld[0]));
        chk("m1.dout_vld", 64'(if1.dout_vld), 64'(e_dvld[1]));
    endtask

    // Inputs are set while the clock is low; sample at the following negedge.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        model_check();
    endtask

    task automatic set_idle();
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wr_inv = 1'b0;
        rd_addr = '0; rd_tag = '0; wr_addr = '0; wr_way = '0; din = '0;
    endtask

    typedef struct {
        bit rst; bit re; int ra; int rt; bit we; bit inv; int wa; int ww; int wd;
        bit rdy; bit val; bit hit; int way; bit multi; int dvld; int dout; bit hit1; int dvld1;
    } vec_t;

    function automatic vec_t mk(bit rst, bit re, int ra, int rt, bit we, bit inv, int wa,
                                int ww, int wd, bit rdy, bit val, bit hit, int way,
                                bit multi, int dvld, int dout, bit hit1, int dvld1);
        vec_t v;
        v.rst = rst; v.re = re; v.ra = ra; v.rt = rt; v.we = we; v.inv = inv;
        v.wa = wa; v.ww = ww; v.wd = wd; v.rdy = rdy; v.val = val; v.hit = hit;
        v.way = way; v.multi = multi; v.dvld = dvld; v.dout = dout; v.hit1 = hit1;
        v.dvld1 = dvld1;
        return v;
    endfunction

    vec_t tbl [27];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst re ra  rt   we inv wa ww wd    rdy val hit way mul dvld dout    h1 dv1
        tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0,    1, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[9]  = mk(0, 1, 5, 'h2A, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,    1, 0, 5, 1, 'h2A, 1, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[11] = mk(0, 1, 5, 'h2A, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 'h0000, 0, 0);
        tbl[12] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1, 1, 1, 1, 0, 2, 'h1500, 1, 2);
        tbl[13] = mk(0, 0, 0, 0,    1, 0, 5, 0, 'h2A, 1, 0, 1, 1, 0, 2, 'h1500, 1, 2);
        tbl[14] = mk(0, 1, 5, 'h2A, 0, 0, 0, 0, 0,    1, 0, 1, 1, 0, 2, 'h1500, 1, 2);
        tbl[15] = mk(0, 0, 0, 0,    1, 1, 5, 0, 0,    1, 1, 1, 0, 1, 3, 'h152A, 1, 3);
        tbl[16] = mk(0, 1, 5, 'h2A, 0, 0, 0, 0, 0,    1, 0, 1, 0, 1, 3, 'h152A, 1, 3);
        tbl[17] = mk(0, 1, 3, 'h11, 1, 0, 3, 0, 'h11, 1, 1, 1, 1, 0, 2, 'h152A, 1, 2);
        tbl[18] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1, 1, 1, 0, 0, 1, 'h0011, 0, 0);
        tbl[19] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1, 0, 1, 0, 0, 1, 'h0011, 0, 0);
        tbl[20] = mk(0, 0, 0, 0,    1, 0, 0, 0, 'h01, 1, 0, 1, 0, 0, 1, 'h0011, 0, 0);
        tbl[21] = mk(0, 0, 0, 0,    1, 0, 1, 1, 'h02, 1, 0, 1, 0, 0, 1, 'h0011, 0, 0);
        tbl[22] = mk(0, 1, 0, 'h01, 1, 0, 2, 0, 'h03, 1, 0, 1, 0, 0, 1, 'h0011, 0, 0);
        tbl[23] = mk(0, 1, 1, 'h02, 0, 0, 0, 0, 0,    1, 1, 1, 0, 0, 1, 'h0001, 1, 1);
        tbl[24] = mk(0, 1, 2, 'h05, 0, 0, 0, 0, 0,    1, 1, 1, 1, 0, 2, 'h0100, 1, 2);
        tbl[25] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 1, 'h0003, 0, 1);
        tbl[26] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 1, 'h0003, 0, 1);

        set_idle();
        reset = 1'b1;

        // Directed vectors: reset, sweep, hit/multi/invalidate, collision, back-to-back.
        for (int i = 0; i < 27; i++) begin
            reset   = tbl[i].rst;
            rd_en   = tbl[i].re;   rd_addr = AW'(tbl[i].ra); rd_tag = DW'(tbl[i].rt);
            wr_en   = tbl[i].we;   wr_inv  = tbl[i].inv;     wr_addr = AW'(tbl[i].wa);
            wr_way  = WW'(tbl[i].ww); din  = DW'(tbl[i].wd);
            cycle();
            chk("t.ready",    64'(if0.ready),    64'(tbl[i].rdy));
            chk("t.rd_valid", 64'(if0.rd_valid), 64'(tbl[i].val));
            chk("t.rd_hit",   64'(if0.rd_hit),   64'(tbl[i].hit));
            chk("t.rd_way",   64'(if0.rd_way),   64'(tbl[i].way));
            chk("t.rd_multi", 64'(if0.rd_multi), 64'(tbl[i].multi));
            chk("t.dout_vld", 64'(if0.dout_vld), 64'(tbl[i].dvld));
            chk("t.dout",     64'(if0.dout),     64'(tbl[i].dout));
            chk("t.rd_hit1",  64'(if1.rd_hit),   64'(tbl[i].hit1));
            chk("t.dout_vld1",64'(if1.dout_vld), 64'(tbl[i].dvld1));
        end

        // Fill every entry, abort an in-flight read with reset, re-sweep.
        for (int idx = 0; idx < DEPTH; idx++)
            for (int w = 0; w < NW; w++) begin
                set_idle();
                wr_en = 1'b1; wr_addr = AW'(idx); wr_way = WW'(w); din = DW'(64 + idx*2 + w);
                cycle();
            end
        set_idle();
        rd_en = 1'b1; rd_addr = 3'd7; rd_tag = 7'h4E;
        cycle();
        set_idle();
        reset = 1'b1;
        cycle();
        chk("abort.rd_valid", 64'(if0.rd_valid), 64'd0);
        set_idle();
        for (int k = 0; k < DEPTH; k++) begin
            cycle();
            chk("sweep.ready", 64'(if0.ready), 64'(k == DEPTH - 1));
        end
        rd_en = 1'b1; rd_addr = 3'd7; rd_tag = 7'h4E;
        cycle();
        set_idle();
        cycle();
        chk("swept.rd_valid", 64'(if0.rd_valid), 64'd1);
        chk("swept.rd_hit",   64'(if0.rd_hit),   64'd0);
        chk("swept.dout",     64'(if0.dout),     64'd0);
        chk("swept.dout_vld", 64'(if0.dout_vld), 64'd0);

        // Randomized traffic with small tag/index ranges to provoke hits,
        // multi-hits, collisions and occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            rd_tag  = DW'($urandom_range(0, 3));
            wr_en   = 1'($urandom_range(0, 1));
            wr_inv  = ($urandom_range(0, 3) == 0);
            wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom_range(0, DEPTH - 1));
            wr_way  = WW'($urandom_range(0, NW - 1));
            din     = DW'($urandom_range(0, 3));
            cycle();
        end
        set_idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/tag_ram_cmp_rw.md
Name: tag_ram_cmp_rw

Overview:
- Parametrised successor to the single-port synchronous-read tag RAM.
- Multi-way tag store with separate read and write ports and a per-entry valid bit.
- Performs the tag compare in the read stage, so the cache controller gets hit, way and data one cycle after the request.
- Replaces file-based memory initialisation with a hardware clear sweep after reset. Sits between the cache controller and the tag lookup path.

Parameters:
- AWIDTH, 3: index width; DEPTH = 1 << AWIDTH entries per way.
- DWIDTH, 7: tag width.
- WAYS, 2: number of ways, 1..8; WWIDTH = max(1, clog2(WAYS)).
- BYPASS, 1: 1 = write-first on a same-index read/write collision; 0 = read-first.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high when the clear sweep is done and requests are accepted.
- rd_en  in  1  read/compare request.
- rd_addr  in  AWIDTH  read index.
- rd_tag  in  DWIDTH  tag to compare.
- wr_en  in  1  write request.
- wr_inv  in  1  qualifies wr_en: 1 = invalidate the entry, 0 = write tag and set valid.
- wr_addr  in  AWIDTH  write index.
- wr_way  in  WWIDTH  target way.
- din  in  DWIDTH  write tag.
- rd_valid  out  1  one-cycle pulse marking valid read results.
- rd_hit  out  1  some way is valid and its tag equals rd_tag.
- rd_way  out  WWIDTH  lowest-numbered hitting way; 0 on a miss.
- rd_multi  out  1  more than one way hit (error flag).
- dout  out  WAYS*DWIDTH  tags of all ways; way w occupies bits [w*DWIDTH +: DWIDTH].
- dout_vld  out  WAYS  valid bit of each way.

Behaviour:
- FSM states are INIT and RUN.
- reset=1 in any state forces INIT on the next edge and clears the sweep counter to 0.
- The following outputs reset to 0: ready, rd_valid, rd_hit, rd_way, rd_multi, dout, dout_vld.
- INIT:
  - Each cycle, write tag 0 and valid 0 to the index given by the counter, in all ways.
  - The counter (AWIDTH bits) increments.
  - When the counter reaches DEPTH-1, that write completes and the next state is RUN.
  - ready=0 throughout INIT. rd_en and wr_en are ignored: no pulse, no array change.
  - Sweep length is exactly DEPTH cycles after reset deasserts; ready rises on cycle DEPTH+1.
- RUN:
  - ready=1.
  - Write: on wr_en at edge N, the array updates at edge N. wr_inv=1 clears only the valid bit and keeps the tag. A wr_way value >= WAYS is ignored.
  - Read: on rd_en at edge N, the index and rd_tag are latched. At edge N+1, rd_valid=1 and dout, dout_vld, rd_hit, rd_way and rd_multi are registered results.
  - rd_valid deasserts when there is no new read. Data outputs hold their last values.
  - Compare is performed per way: hit_w = valid_w AND (tag_w == rd_tag). rd_multi = popcount(hit) > 1.
  - Collision (rd_en and wr_en in the same cycle, rd_addr == wr_addr):
    - BYPASS=1: the result reflects the new write for wr_way, including an invalidate.
    - BYPASS=0: the result reflects the pre-write contents.
  - Reads and writes to different indices are fully independent.
- Reset mid-operation: an in-flight read produces no rd_valid pulse, and the array is re-swept.
- No combinational path from inputs to outputs.

Decomposition:
- Package tag_ram_pkg:
  - FSM state enum (INIT, RUN).
  - clog2 function.
  - Way-select width helper.
- One sub-module, tag_ram_way: a single-way storage array plus valid vector.
  - Has write and clear ports and a registered read.
  - Instantiated WAYS times by generate.
  - The compare, priority encoder, bypass mux and FSM stay in the top module.

Test Plan:
- Reset with AWIDTH=3: ready stays 0 for 8 cycles after reset falls, then rises. rd_en issued during INIT gives no rd_valid.
- Write tag 7'h2A to way 1, index 5. Read index 5 with rd_tag=7'h2A -> next cycle rd_valid=1, rd_hit=1, rd_way=1, dout_vld=2'b10.
- Same index as above, write tag 7'h2A to way 0, then read with 7'h2A -> rd_hit=1, rd_way=0, rd_multi=1. Invalidate way 0 and re-read -> rd_way=1, rd_multi=0, tag 7'h2A still on dout way 0.
- Same-cycle read and write of index 3 with tag 7'h11, way 0:
  - BYPASS=1 -> rd_hit=1.
  - BYPASS=0 (fresh array) -> rd_hit=0, dout_vld=0.
- Fill all ways and indices, assert reset for 1 cycle, let the sweep complete, read index 7 -> rd_hit=0, dout=0, dout_vld=0.
- Back-to-back reads of indices 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses with matching results. An idle cycle after that -> rd_valid=0 while dout holds.
